// File: rtl/ff_bank_cfg.sv
// ff_bank_cfg
//   Bank of N independent single-bit storage channels. Each channel runs as an
//   SR, JK, D or T flip-flop, selected at runtime by its own 2-bit mode
//   register. A global enable gates all data updates. A sticky per-channel
//   flag records any enabled SR-mode cycle that had S=R=1.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset (priority over all inputs)
//   en            1 = channels update this cycle, 0 = all channels hold
//   a   [N]       S / J / D / T input per channel
//   b   [N]       R / K input per channel (ignored in D and T modes)
//   mode_we       write mode_wdata into channels selected by mode_mask
//   mode_mask [N] channel select for the mode write
//   mode_wdata[2] mode value (00=SR, 01=JK, 10=D, 11=T)
//   conflict_clr  clear all sticky conflict flags
//   q   [N]       registered channel state
//   qn  [N]       ~q
//   mode_o [2N]   mode of channel i at bits [2i+1:2i]
//   conflict [N]  sticky S=R=1 flag per channel
//
// No valid/ready handshakes: every input is sampled on every rising edge.

module ff_bank_cfg #(
  parameter int             N          = 4,
  parameter logic [N-1:0]   RESET_VAL  = '0,
  parameter logic [1:0]     RESET_MODE = 2'b00,
  parameter int             SR_BOTH    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             mode_we,
  input  logic [N-1:0]     mode_mask,
  input  logic [1:0]       mode_wdata,
  input  logic             conflict_clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qn,
  output logic [2*N-1:0]   mode_o,
  output logic [N-1:0]     conflict
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [2*N-1:0] mode_q;
  logic [2*N-1:0] mode_next;
  logic [N-1:0]   q_next;
  logic [N-1:0]   conflict_next;

  // All decisions use the mode held before this edge, so a mode write and a
  // data update on the same edge see the old mode for the data update.
  always_comb begin
    q_next        = q;
    mode_next     = mode_q;
    conflict_next = conflict;
    for (int i = 0; i < N; i++) begin
      if (mode_we && mode_mask[i]) begin
        mode_next[2*i +: 2] = mode_wdata;
      end

      if (conflict_clr) begin
        conflict_next[i] = 1'b0;
      end

      if (en) begin
        unique case (mode_q[2*i +: 2])
          MODE_SR: begin
            unique case ({a[i], b[i]})
              2'b00: q_next[i] = q[i];
              2'b01: q_next[i] = 1'b0;
              2'b10: q_next[i] = 1'b1;
              default: begin
                if (SR_BOTH == 1)      q_next[i] = 1'b0;
                else if (SR_BOTH == 2) q_next[i] = 1'b1;
                else                   q_next[i] = q[i];
                // Set is applied after clear so a same-edge set wins.
                conflict_next[i] = 1'b1;
              end
            endcase
          end
          MODE_JK: begin
            unique case ({a[i], b[i]})
              2'b00:   q_next[i] = q[i];
              2'b01:   q_next[i] = 1'b0;
              2'b10:   q_next[i] = 1'b1;
              default: q_next[i] = ~q[i];
            endcase
          end
          MODE_D:  q_next[i] = a[i];
          MODE_T:  q_next[i] = a[i] ? ~q[i] : q[i];
          default: q_next[i] = q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= RESET_VAL;
      mode_q   <= {N{RESET_MODE}};
      conflict <= '0;
    end else begin
      q        <= q_next;
      mode_q   <= mode_next;
      conflict <= conflict_next;
    end
  end

  assign qn     = ~q;
  assign mode_o = mode_q;

endmodule
